baud_ctrl: RTL and testbench

Programmable baud-rate controller for the UART. It replaces the fixed-divisor tick generator with a runtime-loadable divisor register. It generates the 16x oversampling tick used by the receiver and the 1x bit tick used by the transmitter. Divisor changes are accepted through a write/acknowledge handshake and applied only on a bit boundary, so a running frame never sees a partial bit period.

---
 rtl/baud_ctrl.sv | 171 +++++++++++++++++
 tb/tb_baud_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/baud_ctrl.sv
// baud_ctrl: programmable UART baud-rate generator.
// Produces a 16x oversampling tick (tick16) and a 1x bit tick (tick1) from a
// runtime-loadable divisor. While ticking, a new divisor waits in a pending
// register and only takes effect on a bit boundary, so a frame in flight
// never sees a shortened or stretched bit.
module baud_ctrl #(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned DIV_RESET = 20
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_wr,
    output logic             div_ack,
    output logic             div_err,
    output logic             busy,
    output logic [DIV_W-1:0] cur_div,
    output logic             tick16,
    output logic             tick1,
    output logic [3:0]       bit_phase
);

    localparam int unsigned      PH_W    = 4;
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_RESET);
    localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(15);

    // OFF: disabled; RUN: ticking, nothing pending; UPD: ticking with a
    // divisor waiting for the next bit boundary.
    typedef enum logic [1:0] {
        S_OFF = 2'd0,
        S_RUN = 2'd1,
        S_UPD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] pend_div;
    logic [DIV_W-1:0] pend_nxt;
    logic [DIV_W-1:0] cur_nxt;
    logic [PH_W-1:0]  phase_nxt;
    logic             tick16_nxt;
    logic             tick1_nxt;
    logic             ack_nxt;
    logic             err_nxt;
    logic             busy_nxt;

    // Decoded conditions used by the next-state logic.
    logic wr_ok;
    logic wr_bad;
    logic wrap;
    logic bit_end;

    // Write validation and divide-counter boundary detection.
    always_comb begin
        wr_ok   = div_wr && (div_in >= DIV_MIN);
        wr_bad  = div_wr && (div_in <  DIV_MIN);
        wrap    = en && (cnt == DIV_W'(cur_div - DIV_ONE));
        bit_end = wrap && (bit_phase == PH_LAST);
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        phase_nxt  = bit_phase;
        pend_nxt   = pend_div;
        cur_nxt    = cur_div;
        busy_nxt   = busy;
        tick16_nxt = 1'b0;
        tick1_nxt  = 1'b0;
        ack_nxt    = 1'b0;
        err_nxt    = wr_bad;

        if (!en) begin
            // Disabled: counters parked at zero, any pending divisor is
            // committed now, and a same-cycle write is applied directly.
            state_nxt = S_OFF;
            cnt_nxt   = '0;
            phase_nxt = '0;
            busy_nxt  = 1'b0;
            if (state == S_UPD) begin
                cur_nxt = pend_div;
                ack_nxt = 1'b1;
            end
            if (wr_ok) begin
                cur_nxt = div_in;
                ack_nxt = 1'b1;
            end
        end else begin
            // Divide counter: one tick16 every cur_div cycles, one tick1
            // every sixteenth tick16.
            if (wrap) begin
                cnt_nxt    = '0;
                tick16_nxt = 1'b1;
                tick1_nxt  = (bit_phase == PH_LAST);
                phase_nxt  = PH_W'(bit_phase + PH_ONE);
            end else begin
                cnt_nxt = DIV_W'(cnt + DIV_ONE);
            end

            case (state)
                S_OFF: begin
                    state_nxt = S_RUN;
                    if (wr_ok) begin
                        cur_nxt = div_in;
                        ack_nxt = 1'b1;
                    end
                end
                S_RUN: begin
                    if (wr_ok) begin
                        pend_nxt  = div_in;
                        busy_nxt  = 1'b1;
                        state_nxt = S_UPD;
                    end
                end
                S_UPD: begin
                    // Commit on the bit boundary; a write landing on the
                    // same edge becomes the next pending value.
                    if (bit_end) begin
                        cur_nxt   = pend_div;
                        ack_nxt   = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = S_RUN;
                    end
                    if (wr_ok) begin
                        pend_nxt  = div_in;
                        busy_nxt  = 1'b1;
                        state_nxt = S_UPD;
                    end
                end
                default: begin
                    state_nxt = S_OFF;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_OFF;
            cnt       <= '0;
            bit_phase <= '0;
            pend_div  <= DIV_RST;
            cur_div   <= DIV_RST;
            busy      <= 1'b0;
            tick16    <= 1'b0;
            tick1     <= 1'b0;
            div_ack   <= 1'b0;
            div_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_phase <= phase_nxt;
            pend_div  <= pend_nxt;
            cur_div   <= cur_nxt;
            busy      <= busy_nxt;
            tick16    <= tick16_nxt;
            tick1     <= tick1_nxt;
            div_ack   <= ack_nxt;
            div_err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_baud_ctrl.sv
// Directed self-checking bench for baud_ctrl.
module tb_baud_ctrl;

    localparam int unsigned DIV_W = 16;

    logic             sys_clk;
    logic             reset_n;
    logic             en;
    logic [DIV_W-1:0] div_in;
    logic             div_wr;
    logic             div_ack;
    logic             div_err;
    logic             busy;
    logic [DIV_W-1:0] cur_div;
    logic             tick16;
    logic             tick1;
    logic [3:0]       bit_phase;

    int n_tests = 0;
    int n_fail  = 0;
    int acks    = 0;

    baud_ctrl #(.DIV_W(DIV_W), .DIV_RESET(20)) dut (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .en        (en),
        .div_in    (div_in),
        .div_wr    (div_wr),
        .div_ack   (div_ack),
        .div_err   (div_err),
        .busy      (busy),
        .cur_div   (cur_div),
        .tick16    (tick16),
        .tick1     (tick1),
        .bit_phase (bit_phase)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    // Cycles until the next tick16 (bounded); acks seen on the way are tallied.
    task automatic wait_tick16(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
            if (div_ack) acks++;
        end while (!tick16 && cyc < 400);
    endtask

    task automatic wait_tick1(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
            if (div_ack) acks++;
        end while (!tick1 && cyc < 2000);
    endtask

    task automatic write_div(input int val);
        div_wr = 1'b1;
        div_in = DIV_W'(val);
        step();
        div_wr = 1'b0;
    endtask

    initial begin
        int c;
        int n_ack;

        reset_n = 1'b0;
        en      = 1'b0;
        div_wr  = 1'b0;
        div_in  = '0;
        @(negedge sys_clk);
        @(negedge sys_clk);

        // Reset values.
        check("rst_cur_div", int'(cur_div), 20);
        check("rst_busy", int'(busy), 0);
        check("rst_tick16", int'(tick16), 0);
        check("rst_tick1", int'(tick1), 0);
        check("rst_phase", int'(bit_phase), 0);
        check("rst_ack", int'(div_ack), 0);

        // Default divisor: tick16 every 20, tick1 on every 16th tick16.
        reset_n = 1'b1;
        en      = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            wait_tick16(c);
            check("t1_period16", c, 20);
            check("t1_phase", int'(bit_phase), i % 16);
            check("t1_tick1", int'(tick1), (i == 16) ? 1 : 0);
        end
        step();
        check("t1_tick16_width", int'(tick16), 0);
        check("t1_tick1_width", int'(tick1), 0);
        wait_tick1(c);
        check("t1_period1", c, 319);

        // Write while disabled applies immediately.
        en = 1'b0;
        step();
        write_div(6);
        check("t2_ack", int'(div_ack), 1);
        check("t2_cur_div", int'(cur_div), 6);
        check("t2_busy", int'(busy), 0);
        step();
        check("t2_ack_width", int'(div_ack), 0);
        en = 1'b1;
        wait_tick16(c);
        check("t2_first16", c, 6);
        wait_tick16(c);
        check("t2_period16", c, 6);

        // Running at 4, write 8 at bit_phase 5; apply waits for the boundary.
        en = 1'b0;
        step();
        write_div(4);
        check("t3_cur_div4", int'(cur_div), 4);
        en = 1'b1;
        for (int i = 0; i < 5; i++) wait_tick16(c);
        check("t3_phase5", int'(bit_phase), 5);
        write_div(8);
        check("t3_busy", int'(busy), 1);
        check("t3_cur_held", int'(cur_div), 4);
        check("t3_no_ack", int'(div_ack), 0);
        for (int i = 1; i <= 11; i++) begin
            wait_tick16(c);
            check("t3_old_period", c, (i == 1) ? 3 : 4);
            if (i < 11) begin
                check("t3_pre_tick1", int'(tick1), 0);
                check("t3_pre_ack", int'(div_ack), 0);
            end else begin
                check("t3_tick1", int'(tick1), 1);
                check("t3_ack_with_tick1", int'(div_ack), 1);
                check("t3_cur_div8", int'(cur_div), 8);
                check("t3_busy_clr", int'(busy), 0);
                check("t3_phase0", int'(bit_phase), 0);
            end
        end
        wait_tick16(c);
        check("t3_new_period16", c, 8);
        wait_tick1(c);
        check("t3_rest_of_bit", c, 120);
        wait_tick1(c);
        check("t3_period1", c, 128);

        // Two writes before the boundary: last wins, single ack.
        en = 1'b0;
        step();
        write_div(4);
        en = 1'b1;
        wait_tick16(c);
        write_div(10);
        check("t4_busy_a", int'(busy), 1);
        step();
        write_div(12);
        check("t4_busy_b", int'(busy), 1);
        check("t4_cur_held", int'(cur_div), 4);
        n_ack = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (div_ack) begin
                n_ack++;
                check("t4_ack_tick1", int'(tick1), 1);
                check("t4_ack_div", int'(cur_div), 12);
            end
        end
        check("t4_ack_count", n_ack, 1);
        check("t4_cur_div", int'(cur_div), 12);
        check("t4_busy_clr", int'(busy), 0);

        // Rejected writes: error pulse, nothing else changes.
        write_div(1);
        check("t5_err1", int'(div_err), 1);
        check("t5_ack1", int'(div_ack), 0);
        check("t5_busy1", int'(busy), 0);
        check("t5_cur1", int'(cur_div), 12);
        step();
        check("t5_err_width", int'(div_err), 0);
        write_div(0);
        check("t5_err0", int'(div_err), 1);
        check("t5_cur0", int'(cur_div), 12);
        write_div(6);
        check("t5_pend_busy", int'(busy), 1);
        check("t5_pend_err", int'(div_err), 0);
        write_div(0);
        check("t5_err_pend", int'(div_err), 1);
        check("t5_busy_kept", int'(busy), 1);
        check("t5_cur_kept", int'(cur_div), 12);

        // Asynchronous reset mid-bit with a write pending.
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_cur_div", int'(cur_div), 20);
        check("t6_busy", int'(busy), 0);
        check("t6_phase", int'(bit_phase), 0);
        check("t6_tick16", int'(tick16), 0);
        check("t6_tick1", int'(tick1), 0);
        check("t6_ack", int'(div_ack), 0);
        check("t6_err", int'(div_err), 0);
        @(negedge sys_clk);
        reset_n = 1'b1;
        acks    = 0;
        wait_tick16(c);
        check("t6_first16", c, 20);
        wait_tick16(c);
        check("t6_period16", c, 20);
        check("t6_no_ack", acks, 0);
        check("t6_cur_after", int'(cur_div), 20);
        check("t6_busy_after", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
